// File: rtl/booth_pkg.sv
// booth_pkg: widths and FSM state shared by the Booth partial-product accumulator.
package booth_pkg;
    localparam int PP_W   = 32;
    localparam int NUM_PP = 8;
    localparam int OPND_W = 16;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;
endpackage

// File: rtl/booth_pp_accum_if.sv
// booth_pp_accum_if: partial-product input and product output handshakes.
interface booth_pp_accum_if;
    import booth_pkg::*;
    logic            in_valid;
    logic            in_ready;
    logic [PP_W-1:0] pp [NUM_PP];
    logic [NUM_PP-1:0] c;
    logic            out_valid;
    logic            out_ready;
    logic [PP_W-1:0] product;
    modport master (output in_valid, pp, c, out_ready, input in_ready, out_valid, product);
    modport slave  (input in_valid, pp, c, out_ready, output in_ready, out_valid, product);
endinterface

// File: rtl/booth_pp_adder.sv
// booth_pp_adder: adds LANES operands onto acc through a carry-save chain and one final CPA.
module booth_pp_adder import booth_pkg::*; #(
    parameter int LANES = 2
) (
    input  logic [PP_W-1:0] acc_i,
    input  logic [PP_W-1:0] ops_i [LANES],
    output logic [PP_W-1:0] sum_o
);
    logic [PP_W-1:0] s, cy;
    always_comb begin
        s  = acc_i;
        cy = '0;
        for (int i = 0; i < LANES; i++)
            {s, cy} = {s ^ cy ^ ops_i[i], ((s & cy) | (s & ops_i[i]) | (cy & ops_i[i])) << 1};
        sum_o = s + cy;
    end
endmodule

// File: rtl/booth_pp_accum.sv
// booth_pp_accum: reduces eight Booth partial products plus negate corrections, LANES per cycle.
module booth_pp_accum import booth_pkg::*; #(
    parameter int LANES = 2
) (
    input  logic            clk,
    input  logic            rst,
    booth_pp_accum_if.slave bus,
    output logic            busy_o
);
    localparam int IW = $clog2(NUM_PP) + 1;
    state_e          state_q;
    logic [IW-1:0]   idx_q;
    logic [PP_W-1:0] acc_q, sum;
    logic [PP_W-1:0] pp_q [NUM_PP];
    logic [PP_W-1:0] ops [LANES];
    for (genvar l = 0; l < LANES; l++) begin : g_mux
        assign ops[l] = pp_q[idx_q[IW-2:0] + (IW-1)'(l)];
    end
    booth_pp_adder #(.LANES(LANES)) u_add (.acc_i(acc_q), .ops_i(ops), .sum_o(sum));
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.product   = acc_q;
    assign busy_o        = state_q != IDLE;
    // Operand bank needs no reset: it is always rewritten on accept before use.
    always_ff @(posedge clk)
        if (state_q == IDLE && bus.in_valid) pp_q <= bus.pp;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    acc_q   <= PP_W'($countones(bus.c));
                    idx_q   <= '0;
                    state_q <= ACC;
                end
                ACC: begin
                    acc_q <= sum;
                    idx_q <= idx_q + IW'(LANES);
                    if (idx_q == IW'(NUM_PP - LANES)) state_q <= DONE;
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_booth_pp_accum.sv
// tb_booth_pp_accum: drives a Booth encoder model into LANES=2 and LANES=8 instances, checks a*b.
module tb_booth_pp_accum;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  c = '0;
    logic [31:0] pp [8];
    int          sel = 0;
    int          errors = 0;
    int          checks = 0;
    logic        busy2, busy8;
    logic        in_ready, out_valid, busy;
    logic [31:0] product;

    booth_pp_accum_if b2 ();
    booth_pp_accum_if b8 ();
    booth_pp_accum #(.LANES(2)) u2 (.clk(clk), .rst(rst), .bus(b2), .busy_o(busy2));
    booth_pp_accum #(.LANES(8)) u8 (.clk(clk), .rst(rst), .bus(b8), .busy_o(busy8));

    assign b2.in_valid  = in_valid && sel == 0;
    assign b8.in_valid  = in_valid && sel == 1;
    assign b2.out_ready = out_ready && sel == 0;
    assign b8.out_ready = out_ready && sel == 1;
    assign b2.pp = pp;
    assign b8.pp = pp;
    assign b2.c  = c;
    assign b8.c  = c;
    assign in_ready  = sel == 1 ? b8.in_ready  : b2.in_ready;
    assign out_valid = sel == 1 ? b8.out_valid : b2.out_valid;
    assign product   = sel == 1 ? b8.product   : b2.product;
    assign busy      = sel == 1 ? busy8        : busy2;

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] ax, bx;
        ax = {{16{a[15]}}, a};
        bx = {{16{b[15]}}, b};
        return ax * bx;
    endfunction

    task automatic encode(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] bx;
        logic [31:0] ax, m;
        logic [2:0]  t;
        bx = {b, 1'b0};
        ax = {{16{a[15]}}, a};
        for (int i = 0; i < 8; i++) begin
            t = bx[2*i +: 3];
            m = (t == 3'b011 || t == 3'b100) ? ax << 1 : (t == 3'b000 || t == 3'b111) ? 32'd0 : ax;
            c[i]  = t[2] && t != 3'b111;
            pp[i] = c[i] ? ~(m << (2*i)) : m << (2*i);
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b);
        int n;
        encode(a, b);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        encode(16'h5A5A, 16'hA5A5);
    endtask

    task automatic recv(output logic [31:0] p, output int lat, input int bp);
        lat = 0;
        while (!out_valid && lat < 50) begin
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        p = product;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || product !== p) begin
                errors++;
                $display("FAIL hold_stable: valid=%b product=%h want 1 %h", out_valid, product, p);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #2 rst = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            checks++;
            if ({out_valid, in_ready, busy} !== 3'b010 || product !== 32'd0) begin
                errors++;
                $display("FAIL reset_state: v/r/b=%b%b%b product=%h want 010 00000000",
                         out_valid, in_ready, busy, product);
            end
        end
        sel = 0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [15:0] av [3] = '{16'h0003, 16'hFFFF, 16'h8000};
        logic [15:0] bv [3] = '{16'h0005, 16'hFFFF, 16'h8000};
        logic [31:0] ev [3] = '{32'h0000000F, 32'h00000001, 32'h40000000};
        logic [31:0] p;
        int lat;
        for (int i = 0; i < 3; i++) begin
            send(av[i], bv[i]);
            recv(p, lat, 0);
            checks++;
            if (p !== ev[i]) begin
                errors++;
                $display("FAIL basic_product[%0d]: got %h want %h", i, p, ev[i]);
            end
            checks++;
            if (lat != (sel == 1 ? 1 : 4)) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, sel == 1 ? 1 : 4);
            end
        end
    endtask

    task automatic test_backpressure;
        int n;
        send(16'h7FFF, 16'h8000);
        n = 0;
        while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
        in_valid = 1'b1;
        encode(16'h0001, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || product !== 32'hC0008000) begin
                errors++;
                $display("FAIL backpressure_hold[%0d]: v/r=%b%b product=%h want 10 c0008000",
                         i, out_valid, in_ready, product);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL backpressure_ignored_in: v/r/b=%b%b%b want 010", out_valid, in_ready, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] prod [2];
        int acc_cyc [2];
        int acc_n, got;
        logic acc_now;
        acc_n = 0;
        got = 0;
        encode(16'd3, 16'd7);
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 2; cyc++) begin
            acc_now = in_ready && in_valid;
            @(posedge clk); #1;
            if (acc_now && acc_n < 2) begin
                acc_cyc[acc_n] = cyc;
                acc_n++;
                if (acc_n == 1) encode(16'hFFF9, 16'd2);
                else in_valid = 1'b0;
            end
            if (out_valid) begin prod[got] = product; got++; end
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (got != 2 || acc_n != 2) begin
            errors++;
            $display("FAIL b2b_count: products=%0d accepts=%0d want 2 2", got, acc_n);
        end else begin
            checks++;
            if (prod[0] !== 32'h15 || prod[1] !== 32'hFFFFFFF2) begin
                errors++;
                $display("FAIL b2b_products: got %h %h want 00000015 fffffff2", prod[0], prod[1]);
            end
            checks++;
            if (acc_cyc[1] - acc_cyc[0] != (sel == 1 ? 3 : 6)) begin
                errors++;
                $display("FAIL b2b_interval: got %0d want %0d", acc_cyc[1] - acc_cyc[0], sel == 1 ? 3 : 6);
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] p;
        int lat;
        send(16'h1234, 16'h0567);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010 || product !== 32'd0) begin
            errors++;
            $display("FAIL abort_async: v/r/b=%b%b%b product=%h want 010 00000000",
                     out_valid, in_ready, busy, product);
        end
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send(16'd10, 16'hFFF6);
        recv(p, lat, 1);
        checks++;
        if (p !== 32'hFFFFFF9C) begin
            errors++;
            $display("FAIL abort_next: got %h want ffffff9c", p);
        end
    endtask

    task automatic test_random(input int n);
        logic [15:0] a, b;
        logic [31:0] p;
        int lat;
        for (int i = 0; i < n; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            send(a, b);
            recv(p, lat, $urandom_range(0, 2));
            checks++;
            if (p !== model(a, b)) begin
                errors++;
                $display("FAIL random_product: a=%h b=%h got %h want %h", a, b, p, model(a, b));
            end
            checks++;
            if (lat != (sel == 1 ? 1 : 4)) begin
                errors++;
                $display("FAIL random_latency: got %0d want %0d", lat, sel == 1 ? 1 : 4);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) pp[i] = '0;
        test_reset;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            test_basic;
            test_backpressure;
            test_back_to_back;
            test_reset_abort;
            test_random(5000);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
